// File: rtl/grid_bank_arbiter_if.sv
// Bus bundle between the grid bank and its host / freemachine requesters.
// The master side drives requests and host writes; the bank (slave) returns acks and data.
interface grid_bank_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int ROW_W   = 6,
  parameter int COL_W   = 9
) ();
  logic                      host_we;
  logic [ROW_W-1:0]          host_row;
  logic [COL_W-1:0]          host_col;
  logic [DATA_W-1:0]         host_wdata;
  logic [NUM_REQ-1:0]        req_read_en;
  logic [NUM_REQ-1:0]        req_write_en;
  logic [NUM_REQ*ROW_W-1:0]  req_row;
  logic [NUM_REQ*COL_W-1:0]  req_col;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        ack_out;
  logic [DATA_W-1:0]         rdata_out;
  logic [31:0]               grant_cnt;

  modport master (
    output host_we, host_row, host_col, host_wdata,
    output req_read_en, req_write_en, req_row, req_col, req_wdata,
    input  ack_out, rdata_out, grant_cnt
  );

  modport slave (
    input  host_we, host_row, host_col, host_wdata,
    input  req_read_en, req_write_en, req_row, req_col, req_wdata,
    output ack_out, rdata_out, grant_cnt
  );
endinterface

// File: rtl/grid_bank_arbiter.sv
// Shared grid-row bank: round-robin single-access-per-cycle arbiter with host fill port.
// state | meaning
// IDLE  | no access pending, ack_out is zero
// RESP  | an access was granted last cycle, its ack (and read data) is on the outputs
module grid_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int ROWS    = 32,
  parameter int CHUNKS  = 4,
  parameter int ROW_W   = 6,
  parameter int COL_W   = 9
) (
  input logic clock,
  input logic reset,
  grid_bank_arbiter_if.slave bus
);

  localparam int LOG_DW = $clog2(DATA_W);
  localparam int CHK_W  = COL_W - LOG_DW;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH  = ROWS * CHUNKS;
  localparam int AW     = $clog2(DEPTH);

  typedef enum logic {IDLE, RESP} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] elig;
  logic               gnt_vld;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   ptr_next;
  logic [ROW_W-1:0]   g_row;
  logic [CHK_W-1:0]   g_chunk;
  logic [DATA_W-1:0]  g_wdata;
  logic               g_wr;
  logic               g_in_range;
  logic [AW-1:0]      g_addr;
  logic [CHK_W-1:0]   h_chunk;
  logic               h_in_range;
  logic [AW-1:0]      h_addr;
  logic               unused_col_lsbs;

  // Bits below the chunk boundary carry no information (addresses are chunk aligned).
  assign unused_col_lsbs = ^{bus.host_col[LOG_DW-1:0], bus.req_col};

  // A requester acked this cycle is still showing its old address, so skip it.
  assign busy = (state == RESP) ? bus.ack_out : '0;
  assign elig = (bus.req_read_en | bus.req_write_en) & ~busy & {NUM_REQ{~bus.host_we}};

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld && elig[(int'(rr_ptr) + k) % NUM_REQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign ptr_next   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign g_row      = bus.req_row[int'(gnt_idx)*ROW_W +: ROW_W];
  assign g_chunk    = bus.req_col[int'(gnt_idx)*COL_W + LOG_DW +: CHK_W];
  assign g_wdata    = bus.req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
  assign g_wr       = bus.req_write_en[gnt_idx];
  assign g_in_range = (int'(g_row) < ROWS) && (int'(g_chunk) < CHUNKS);
  assign g_addr     = AW'(int'(g_row) * CHUNKS + int'(g_chunk));

  assign h_chunk    = bus.host_col[COL_W-1:LOG_DW];
  assign h_in_range = (int'(bus.host_row) < ROWS) && (int'(h_chunk) < CHUNKS);
  assign h_addr     = AW'(int'(bus.host_row) * CHUNKS + int'(h_chunk));

  // Storage is never cleared; out-of-range writes are dropped.
  always_ff @(posedge clock) begin
    if (bus.host_we) begin
      if (h_in_range) mem[h_addr] <= bus.host_wdata;
    end else if (gnt_vld && g_wr && g_in_range) begin
      mem[g_addr] <= g_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      bus.ack_out   <= '0;
      bus.rdata_out <= '0;
      bus.grant_cnt <= '0;
    end else begin
      state       <= IDLE;
      bus.ack_out <= '0;
      if (gnt_vld) begin
        state                <= RESP;
        rr_ptr               <= ptr_next;
        bus.ack_out[gnt_idx] <= 1'b1;
        if (!g_wr) bus.rdata_out <= g_in_range ? mem[g_addr] : '0;
        if (bus.grant_cnt != '1) bus.grant_cnt <= bus.grant_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_grid_bank_arbiter.sv
// Directed bench for grid_bank_arbiter: host fill, round-robin order, out-of-range,
// host priority, write-then-read forwarding through memory, and reset mid-access.
module tb_grid_bank_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 64;
  localparam int ROWS    = 32;
  localparam int ROW_W   = 6;
  localparam int COL_W   = 9;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  grid_bank_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  grid_bank_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] hval(input int r, input int c);
    return 64'hC0DE_0000_0000_0000 | (64'(r) << 8) | 64'(c);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit rd, input bit wr, input int row, input int chunk,
                         input logic [63:0] wd);
    bus.req_read_en[i]              = rd;
    bus.req_write_en[i]             = wr;
    bus.req_row[i*ROW_W +: ROW_W]   = ROW_W'(row);
    bus.req_col[i*COL_W +: COL_W]   = COL_W'(chunk * DATA_W);
    bus.req_wdata[i*DATA_W +: DATA_W] = wd;
  endtask

  task automatic host_write(input int row, input int chunk, input logic [63:0] wd);
    bus.host_we    = 1'b1;
    bus.host_row   = ROW_W'(row);
    bus.host_col   = COL_W'(chunk * DATA_W);
    bus.host_wdata = wd;
  endtask

  // One isolated access by requester i: grant edge, ack check, then release.
  task automatic single(input string tag, input int i, input bit wr, input int row, input int chunk,
                        input logic [63:0] wd, input logic [63:0] exp_rd);
    set_req(i, !wr, wr, row, chunk, wd);
    step();
    chk({tag, "_ack"}, 64'(bus.ack_out), 64'(4'b0001 << i));
    if (!wr) chk({tag, "_rdata"}, bus.rdata_out, exp_rd);
    bus.req_read_en[i]  = 1'b0;
    bus.req_write_en[i] = 1'b0;
    step();
    chk({tag, "_idle"}, 64'(bus.ack_out), 64'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset            = 1'b1;
    bus.host_we      = 1'b0;
    bus.host_row     = '0;
    bus.host_col     = '0;
    bus.host_wdata   = '0;
    bus.req_read_en  = '0;
    bus.req_write_en = '0;
    bus.req_row      = '0;
    bus.req_col      = '0;
    bus.req_wdata    = '0;
    step();
    step();
    chk("rst_ack", 64'(bus.ack_out), 64'd0);
    chk("rst_rdata", bus.rdata_out, 64'd0);
    chk("rst_cnt", 64'(bus.grant_cnt), 64'd0);
    reset = 1'b0;

    // 1) host fill rows 0..3, then requester 0 walks row 2
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        host_write(r, c, hval(r, c));
        step();
      end
    bus.host_we = 1'b0;
    chk("host_no_ack", 64'(bus.ack_out), 64'd0);
    for (int c = 0; c < 4; c++) begin
      set_req(0, 1'b1, 1'b0, 2, c, 64'd0);
      step();
      chk("t1_ack", 64'(bus.ack_out), 64'h1);
      chk("t1_rdata", bus.rdata_out, hval(2, c));
      if (c == 3) bus.req_read_en[0] = 1'b0;
      step();
      chk("t1_no_regrant", 64'(bus.ack_out), 64'h0);
      chk("t1_rdata_hold", bus.rdata_out, hval(2, c));
    end
    chk("t1_cnt", 64'(bus.grant_cnt), 64'd4);

    // 2) round robin from ptr 0 (reset keeps memory)
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, i, i, 64'd0);
    for (int n = 0; n < 6; n++) begin
      step();
      chk("t2_ack", 64'(bus.ack_out), 64'(4'b0001 << (n % 4)));
      chk("t2_rdata", bus.rdata_out, hval(n % 4, n % 4));
    end
    bus.req_read_en = '0;
    step();
    chk("t2_idle", 64'(bus.ack_out), 64'd0);
    chk("t2_cnt", 64'(bus.grant_cnt), 64'd6);

    // 3) out-of-range accesses by requester 1 (ptr is 2)
    single("t3_rd_rows", 1, 1'b0, ROWS, 0, 64'd0, 64'd0);
    single("t3_rd_rows5", 1, 1'b0, ROWS + 5, 0, 64'd0, 64'd0);
    single("t3_wr_rows", 1, 1'b1, ROWS, 0, 64'hDEAD_BEEF_0000_0001, 64'd0);
    single("t3_wr_chunk", 1, 1'b1, 1, 4, 64'hDEAD_BEEF_0000_0002, 64'd0);
    single("t3_chk_r0c0", 1, 1'b0, 0, 0, 64'd0, hval(0, 0));
    single("t3_chk_r2c0", 1, 1'b0, 2, 0, 64'd0, hval(2, 0));
    chk("t3_cnt", 64'(bus.grant_cnt), 64'd12);

    // 4) host priority for 3 cycles; ptr stays at 2 so requester 3 goes first
    set_req(0, 1'b1, 1'b0, 5, 2, 64'd0);
    set_req(3, 1'b1, 1'b0, 5, 0, 64'd0);
    for (int c = 0; c < 3; c++) begin
      host_write(5, c, hval(5, c));
      step();
      chk("t4_host_block", 64'(bus.ack_out), 64'd0);
    end
    bus.host_we = 1'b0;
    step();
    chk("t4_first_ack", 64'(bus.ack_out), 64'h8);
    chk("t4_first_rdata", bus.rdata_out, hval(5, 0));
    step();
    chk("t4_second_ack", 64'(bus.ack_out), 64'h1);
    chk("t4_second_rdata", bus.rdata_out, hval(5, 2));
    bus.req_read_en = '0;
    step();
    chk("t4_idle", 64'(bus.ack_out), 64'd0);

    // 5) write by 2 then read of the same word by 3 (ptr is 1)
    set_req(2, 1'b0, 1'b1, 7, 1, 64'hA5A5);
    set_req(3, 1'b1, 1'b0, 7, 1, 64'd0);
    step();
    chk("t5_wr_ack", 64'(bus.ack_out), 64'h4);
    bus.req_write_en[2] = 1'b0;
    step();
    chk("t5_rd_ack", 64'(bus.ack_out), 64'h8);
    chk("t5_rdata", bus.rdata_out, 64'hA5A5);
    bus.req_read_en[3] = 1'b0;
    step();
    chk("t5_idle", 64'(bus.ack_out), 64'd0);
    chk("t5_cnt", 64'(bus.grant_cnt), 64'd16);

    // 6) reset on the grant edge discards the ack; memory survives
    set_req(0, 1'b1, 1'b0, 3, 2, 64'd0);
    reset = 1'b1;
    step();
    chk("t6_rst_ack", 64'(bus.ack_out), 64'd0);
    chk("t6_rst_cnt", 64'(bus.grant_cnt), 64'd0);
    reset = 1'b0;
    step();
    chk("t6_post_ack", 64'(bus.ack_out), 64'h1);
    chk("t6_post_rdata", bus.rdata_out, hval(3, 2));
    chk("t6_post_cnt", 64'(bus.grant_cnt), 64'd1);
    bus.req_read_en = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
